// File: rtl/mem_stage.sv
// Memory-access stage: holds one instruction from execute, merges the
// synchronous-SRAM read word into the load result, and hands it to writeback.
module mem_stage #(
    parameter int unsigned ES_TO_MS_BUS_WD = 111,
    parameter int unsigned MS_TO_WS_BUS_WD = 70
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       ws_allowin,
    output logic                       ms_allowin,
    input  logic                       es_to_ms_valid,
    input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
    output logic                       ms_to_ws_valid,
    output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
    input  logic [31:0]                data_sram_rdata,
    output logic [37:0]                ms_dest_withvalid
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned DEST_W = 5;

    logic                       ms_valid;
    logic                       ms_ready_go;
    logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus_r;

    logic [DATA_W-1:0] rt_value;
    logic              lwl;
    logic              lwr;
    logic [1:0]        load_choice;
    logic              lb;
    logic              lbu;
    logic              lh;
    logic              lhu;
    logic              res_from_mem;
    logic              gr_we;
    logic [DEST_W-1:0] dest;
    logic [DATA_W-1:0] exe_result;
    logic [DATA_W-1:0] pc;

    logic [7:0]        load_byte;
    logic [15:0]       load_half;
    logic [DATA_W-1:0] final_result;
    logic              fwd_valid;

    // Unpack the held execute-stage payload
    assign {rt_value, lwl, lwr, load_choice, lb, lbu, lh, lhu,
            res_from_mem, gr_we, dest, exe_result, pc} = es_to_ms_bus_r;

    // Single-cycle stage: never stalls on its own
    assign ms_ready_go    = 1'b1;
    assign ms_allowin     = !ms_valid || (ms_ready_go && ws_allowin);
    assign ms_to_ws_valid = ms_valid && ms_ready_go;

    // Stage occupancy; reset drops the held instruction immediately
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ms_valid <= 1'b0;
        end else if (ms_allowin) begin
            ms_valid <= es_to_ms_valid;
        end
    end

    // Payload register only moves on a real transfer, bubbles leave it untouched
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            es_to_ms_bus_r <= '0;
        end else if (es_to_ms_valid && ms_allowin) begin
            es_to_ms_bus_r <= es_to_ms_bus;
        end
    end

    // Sub-word extraction from the read word
    always_comb begin
        load_byte = data_sram_rdata[7:0];
        load_half = load_choice[1] ? data_sram_rdata[31:16] : data_sram_rdata[15:0];
        case (load_choice)
            2'd0:    load_byte = data_sram_rdata[7:0];
            2'd1:    load_byte = data_sram_rdata[15:8];
            2'd2:    load_byte = data_sram_rdata[23:16];
            default: load_byte = data_sram_rdata[31:24];
        endcase
    end

    // Result merge; load flags resolved by fixed priority if several are set
    always_comb begin
        final_result = exe_result;
        if (res_from_mem) begin
            if (lwl) begin
                case (load_choice)
                    2'd0:    final_result = {data_sram_rdata[7:0],  rt_value[23:0]};
                    2'd1:    final_result = {data_sram_rdata[15:0], rt_value[15:0]};
                    2'd2:    final_result = {data_sram_rdata[23:0], rt_value[7:0]};
                    default: final_result = data_sram_rdata;
                endcase
            end else if (lwr) begin
                case (load_choice)
                    2'd0:    final_result = data_sram_rdata;
                    2'd1:    final_result = {rt_value[31:24], data_sram_rdata[31:8]};
                    2'd2:    final_result = {rt_value[31:16], data_sram_rdata[31:16]};
                    default: final_result = {rt_value[31:8],  data_sram_rdata[31:24]};
                endcase
            end else if (lb) begin
                final_result = {{24{load_byte[7]}}, load_byte};
            end else if (lbu) begin
                final_result = {24'd0, load_byte};
            end else if (lh) begin
                final_result = {{16{load_half[15]}}, load_half};
            end else if (lhu) begin
                final_result = {16'd0, load_half};
            end else begin
                final_result = data_sram_rdata;
            end
        end
    end

    // Register 0 is hardwired, so it is never a bypass source
    assign fwd_valid = ms_valid && gr_we && (dest != DEST_W'(0));

    assign ms_to_ws_bus      = MS_TO_WS_BUS_WD'({gr_we, dest, final_result, pc});
    assign ms_dest_withvalid = {final_result, fwd_valid, dest};

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed load cases, stall, forwarding,
// asynchronous reset, and a randomized run against a behavioural model.
module tb_mem_stage;

    localparam int unsigned ES_W = 111;
    localparam int unsigned WS_W = 70;

    logic            clk = 1'b0;
    logic            reset;
    logic            ws_allowin;
    logic            ms_allowin;
    logic            es_to_ms_valid;
    logic [ES_W-1:0] es_to_ms_bus;
    logic            ms_to_ws_valid;
    logic [WS_W-1:0] ms_to_ws_bus;
    logic [31:0]     data_sram_rdata;
    logic [37:0]     ms_dest_withvalid;

    int errors = 0;
    int checks = 0;

    mem_stage #(.ES_TO_MS_BUS_WD(ES_W), .MS_TO_WS_BUS_WD(WS_W)) dut (
        .clk               (clk),
        .reset             (reset),
        .ws_allowin        (ws_allowin),
        .ms_allowin        (ms_allowin),
        .es_to_ms_valid    (es_to_ms_valid),
        .es_to_ms_bus      (es_to_ms_bus),
        .ms_to_ws_valid    (ms_to_ws_valid),
        .ms_to_ws_bus      (ms_to_ws_bus),
        .data_sram_rdata   (data_sram_rdata),
        .ms_dest_withvalid (ms_dest_withvalid)
    );

    always #5 clk = ~clk;

    function automatic logic [ES_W-1:0] mk_bus(
        input logic [31:0] rt, input logic f_lwl, input logic f_lwr, input logic [1:0] lc,
        input logic f_lb, input logic f_lbu, input logic f_lh, input logic f_lhu,
        input logic rfm, input logic we, input logic [4:0] dst,
        input logic [31:0] exe, input logic [31:0] pcv);
        return {rt, f_lwl, f_lwr, lc, f_lb, f_lbu, f_lh, f_lhu, rfm, we, dst, exe, pcv};
    endfunction

    // Load semantics expressed as byte shifts and masks over the 32-bit word
    function automatic logic [31:0] ref_result(input logic [ES_W-1:0] b, input logic [31:0] rd);
        logic [31:0] rt;
        logic [7:0]  by;
        logic [15:0] hw;
        int          c;
        rt = b[110:79];
        c  = int'(b[76:75]);
        by = 8'(rd >> (8 * c));
        hw = 16'(rd >> (16 * (c / 2)));
        if (!b[70]) return b[63:32];
        if (b[78])  return (rd << (8 * (3 - c))) | (rt & ((32'h1 << (8 * (3 - c))) - 32'h1));
        if (b[77])  return (rd >> (8 * c)) | (rt & ~(32'hFFFF_FFFF >> (8 * c)));
        if (b[74])  return {{24{by[7]}}, by};
        if (b[73])  return {24'd0, by};
        if (b[72])  return {{16{hw[15]}}, hw};
        if (b[71])  return {16'd0, hw};
        return rd;
    endfunction

    function automatic logic [ES_W-1:0] rand_bus();
        logic [ES_W-1:0] b;
        b = ES_W'({$urandom(), $urandom(), $urandom(), $urandom()});
        if ($urandom_range(0, 1) == 0) begin
            b[78:71] = '0;
            case ($urandom_range(0, 6))
                0: b[78] = 1'b1;
                1: b[77] = 1'b1;
                2: b[74] = 1'b1;
                3: b[73] = 1'b1;
                4: b[72] = 1'b1;
                5: b[71] = 1'b1;
                default: ;
            endcase
        end
        if ($urandom_range(0, 5) == 0) b[68:64] = 5'd0;
        return b;
    endfunction

    // Present one instruction for a single accept edge, then leave it in the stage
    task automatic issue(input logic [ES_W-1:0] b, input logic [31:0] rd);
        @(negedge clk);
        ws_allowin     = 1'b1;
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = b;
        @(posedge clk);
        @(negedge clk);
        es_to_ms_valid  = 1'b0;
        ws_allowin      = 1'b0;
        data_sram_rdata = rd;
        #1;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        es_to_ms_valid = 1'b0;
        ws_allowin = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++; if (ms_to_ws_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", ms_to_ws_valid); end
        checks++; if (ms_allowin !== 1'b1) begin errors++; $display("FAIL reset_allowin got=%b exp=1", ms_allowin); end
        checks++; if (ms_to_ws_bus !== '0) begin errors++; $display("FAIL reset_bus got=%h exp=0", ms_to_ws_bus); end
        checks++; if (ms_dest_withvalid !== 38'd0) begin errors++; $display("FAIL reset_fwd got=%h exp=0", ms_dest_withvalid); end
        @(negedge clk);
        reset = 1'b0;
        // no capture while es_to_ms_valid stays low after release
        @(negedge clk);
        @(negedge clk);
        checks++; if (ms_to_ws_valid !== 1'b0) begin errors++; $display("FAIL post_reset_idle got=%b exp=0", ms_to_ws_valid); end
    endtask

    task automatic test_loads();
        logic [ES_W-1:0] b;
        logic [31:0] exp_v [8];
        logic [31:0] rdv   [8];
        logic [ES_W-1:0] bs [8];
        bs[0] = mk_bus(32'h0, 0, 0, 2'd2, 1, 0, 0, 0, 1, 1, 5'd3, 32'h0, 32'h100); rdv[0] = 32'h12F4_5678; exp_v[0] = 32'hFFFF_FFF4;
        bs[1] = mk_bus(32'h0, 0, 0, 2'd2, 0, 1, 0, 0, 1, 1, 5'd3, 32'h0, 32'h104); rdv[1] = 32'h12F4_5678; exp_v[1] = 32'h0000_00F4;
        bs[2] = mk_bus(32'h0, 0, 0, 2'd2, 0, 0, 1, 0, 1, 1, 5'd3, 32'h0, 32'h108); rdv[2] = 32'h8001_1234; exp_v[2] = 32'hFFFF_8001;
        bs[3] = mk_bus(32'h0, 0, 0, 2'd3, 0, 0, 0, 1, 1, 1, 5'd3, 32'h0, 32'h10C); rdv[3] = 32'h8001_1234; exp_v[3] = 32'h0000_8001;
        bs[4] = mk_bus(32'hAABBCCDD, 1, 0, 2'd1, 0, 0, 0, 0, 1, 1, 5'd3, 32'h0, 32'h110); rdv[4] = 32'h1122_3344; exp_v[4] = 32'h3344_CCDD;
        bs[5] = mk_bus(32'hAABBCCDD, 0, 1, 2'd1, 0, 0, 0, 0, 1, 1, 5'd3, 32'h0, 32'h114); rdv[5] = 32'h1122_3344; exp_v[5] = 32'hAA11_2233;
        bs[6] = mk_bus(32'hAABBCCDD, 1, 0, 2'd0, 1, 0, 0, 0, 1, 1, 5'd3, 32'h0, 32'h118); rdv[6] = 32'h1122_3344; exp_v[6] = 32'h44BB_CCDD;
        bs[7] = mk_bus(32'h0, 0, 0, 2'd0, 0, 0, 0, 0, 0, 1, 5'd3, 32'hCAFE_F00D, 32'h11C); rdv[7] = 32'h1122_3344; exp_v[7] = 32'hCAFE_F00D;
        for (int i = 0; i < 8; i++) begin
            b = bs[i];
            issue(b, rdv[i]);
            checks++;
            if (ms_to_ws_bus[63:32] !== exp_v[i] || ms_to_ws_valid !== 1'b1)
                begin errors++; $display("FAIL load_%0d got=%h v=%b exp=%h v=1", i, ms_to_ws_bus[63:32], ms_to_ws_valid, exp_v[i]); end
        end
    endtask

    task automatic test_stall();
        logic [ES_W-1:0] a;
        logic [ES_W-1:0] b2;
        a  = mk_bus(32'h0, 0, 0, 2'd0, 0, 0, 0, 0, 0, 1, 5'd7, 32'h1111_2222, 32'h200);
        b2 = mk_bus(32'h0, 0, 0, 2'd0, 0, 0, 0, 0, 0, 1, 5'd9, 32'h3333_4444, 32'h204);
        issue(a, 32'h0);
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = b2;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (ms_allowin !== 1'b0 || ms_to_ws_valid !== 1'b1 || ms_to_ws_bus !== {1'b1, 5'd7, 32'h1111_2222, 32'h200})
                begin errors++; $display("FAIL stall_%0d allowin=%b v=%b bus=%h", i, ms_allowin, ms_to_ws_valid, ms_to_ws_bus); end
            @(negedge clk);
            #1;
        end
        ws_allowin = 1'b1;
        #1;
        checks++; if (ms_allowin !== 1'b1) begin errors++; $display("FAIL stall_release got=%b exp=1", ms_allowin); end
        @(negedge clk);
        es_to_ms_valid = 1'b0;
        ws_allowin = 1'b0;
        #1;
        checks++;
        if (ms_to_ws_valid !== 1'b1 || ms_to_ws_bus !== {1'b1, 5'd9, 32'h3333_4444, 32'h204})
            begin errors++; $display("FAIL stall_next v=%b bus=%h exp_pc=204", ms_to_ws_valid, ms_to_ws_bus); end
    endtask

    task automatic test_fwd();
        issue(mk_bus(32'h0, 0, 0, 2'd0, 0, 0, 0, 0, 0, 1, 5'd0, 32'h5555_AAAA, 32'h300), 32'h0);
        checks++; if (ms_dest_withvalid[5] !== 1'b0) begin errors++; $display("FAIL fwd_dest0 got=%b exp=0", ms_dest_withvalid[5]); end
        issue(mk_bus(32'h0, 0, 0, 2'd0, 0, 0, 0, 0, 0, 1, 5'd5, 32'h5555_AAAA, 32'h304), 32'h0);
        checks++;
        if (ms_dest_withvalid !== {32'h5555_AAAA, 1'b1, 5'd5})
            begin errors++; $display("FAIL fwd_dest5 got=%h exp=%h", ms_dest_withvalid, {32'h5555_AAAA, 1'b1, 5'd5}); end
        issue(mk_bus(32'h0, 0, 0, 2'd0, 0, 0, 0, 0, 0, 0, 5'd5, 32'h5555_AAAA, 32'h308), 32'h0);
        checks++; if (ms_dest_withvalid[5] !== 1'b0) begin errors++; $display("FAIL fwd_nowe got=%b exp=0", ms_dest_withvalid[5]); end
    endtask

    task automatic test_async_reset();
        issue(mk_bus(32'h0, 0, 0, 2'd0, 0, 0, 0, 0, 0, 1, 5'd6, 32'h7777_8888, 32'h400), 32'h0);
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        checks++;
        if (ms_to_ws_valid !== 1'b0 || ms_allowin !== 1'b1 || ms_to_ws_bus !== '0)
            begin errors++; $display("FAIL async_reset v=%b allowin=%b bus=%h", ms_to_ws_valid, ms_allowin, ms_to_ws_bus); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_random();
        logic [ES_W-1:0] slot [$];
        logic [ES_W-1:0] last_bus;
        logic            exp_valid;
        logic [31:0]     exp_res;
        logic            exp_fwd;
        logic            accept;
        apply_reset();
        last_bus = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            ws_allowin      = ($urandom_range(0, 3) != 0);
            es_to_ms_valid  = ($urandom_range(0, 2) != 0);
            es_to_ms_bus    = rand_bus();
            data_sram_rdata = $urandom();
            #1;
            exp_valid = (slot.size() != 0);
            exp_res   = ref_result(last_bus, data_sram_rdata);
            exp_fwd   = exp_valid && last_bus[69] && (last_bus[68:64] != 5'd0);
            checks++; if (ms_to_ws_valid !== exp_valid) begin errors++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", cyc, ms_to_ws_valid, exp_valid); end
            checks++; if (ms_allowin !== (!exp_valid || ws_allowin)) begin errors++; $display("FAIL rnd_allowin cyc=%0d got=%b", cyc, ms_allowin); end
            checks++;
            if (ms_to_ws_bus !== {last_bus[69], last_bus[68:64], exp_res, last_bus[31:0]})
                begin errors++; $display("FAIL rnd_bus cyc=%0d got=%h exp=%h", cyc, ms_to_ws_bus, {last_bus[69], last_bus[68:64], exp_res, last_bus[31:0]}); end
            checks++;
            if (ms_dest_withvalid !== {exp_res, exp_fwd, last_bus[68:64]})
                begin errors++; $display("FAIL rnd_fwd cyc=%0d got=%h exp=%h", cyc, ms_dest_withvalid, {exp_res, exp_fwd, last_bus[68:64]}); end
            @(posedge clk);
            accept = (slot.size() == 0) || ws_allowin;
            if (slot.size() != 0 && ws_allowin) void'(slot.pop_front());
            if (accept && es_to_ms_valid) begin
                slot.push_back(es_to_ms_bus);
                last_bus = es_to_ms_bus;
            end
        end
    endtask

    initial begin
        reset           = 1'b1;
        ws_allowin      = 1'b1;
        es_to_ms_valid  = 1'b0;
        es_to_ms_bus    = '0;
        data_sram_rdata = 32'h0;
        #12;
        test_reset();
        test_loads();
        test_stall();
        test_fwd();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter ES_TO_MS_BUS_WD, default 111, SHALL set the width of the bus from the execute stage.
REQ-002 Parameter MS_TO_WS_BUS_WD, default 70, SHALL set the width of the bus to the writeback stage.
REQ-003 clk  in  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 reset  in  1  SHALL be asynchronous, active-high.
REQ-005 ws_allowin  in  1  SHALL indicate the writeback stage accepts data this cycle.
REQ-006 ms_allowin  out  1  SHALL indicate this stage accepts data from the execute stage.
REQ-007 es_to_ms_valid  in  1  SHALL qualify es_to_ms_bus.
REQ-008 es_to_ms_bus  in  ES_TO_MS_BUS_WD  SHALL carry: rt_value[110:79], lwl[78], lwr[77], load_choice[76:75], lb[74], lbu[73], lh[72], lhu[71], res_from_mem[70], gr_we[69], dest[68:64], exe_result[63:32], pc[31:0].
REQ-009 ms_to_ws_valid  out  1  SHALL qualify ms_to_ws_bus.
REQ-010 ms_to_ws_bus  out  MS_TO_WS_BUS_WD  SHALL carry gr_we[69], dest[68:64], final_result[63:32], pc[31:0].
REQ-011 data_sram_rdata  in  32  SHALL be the synchronous-SRAM read word for the address issued by the execute stage the previous cycle.
REQ-012 ms_dest_withvalid  out  38  SHALL carry {final_result[37:6], fwd_valid[5], dest[4:0]} to decode for bypass and hazard detection.

Function
REQ-013 ms_valid register SHALL load es_to_ms_valid on every edge where ms_allowin=1; hold otherwise.
REQ-014 Bus register SHALL capture es_to_ms_bus only when es_to_ms_valid & ms_allowin; hold otherwise (including on bubbles).
REQ-015 ms_ready_go SHALL be 1 (single-cycle stage, no stall source).
REQ-016 ms_allowin SHALL equal !ms_valid | (ms_ready_go & ws_allowin).
REQ-017 ms_to_ws_valid SHALL equal ms_valid & ms_ready_go.
REQ-018 If res_from_mem=0, final_result SHALL be exe_result.
REQ-019 lb/lbu SHALL select byte rdata[8*load_choice+7 : 8*load_choice], sign- / zero-extended to 32.
REQ-020 lh/lhu SHALL select rdata[15:0] if load_choice[1]=0 else rdata[31:16], sign- / zero-extended; load_choice[0] SHALL be ignored.
REQ-021 lwl by load_choice 0/1/2/3 SHALL give {rdata[7:0],rt[23:0]} / {rdata[15:0],rt[15:0]} / {rdata[23:0],rt[7:0]} / rdata.
REQ-022 lwr by load_choice 0/1/2/3 SHALL give rdata / {rt[31:24],rdata[31:8]} / {rt[31:16],rdata[31:16]} / {rt[31:8],rdata[31:24]}.
REQ-023 res_from_mem=1 with no sub-word/partial flag set SHALL give full-word rdata (lw).
REQ-024 Load-type flags SHALL be mutually exclusive; if several are set, priority lwl > lwr > lb > lbu > lh > lhu.
REQ-025 fwd_valid SHALL equal ms_valid & gr_we & (dest != 0); dest 0 never forwards.
REQ-026 ms_dest_withvalid and ms_to_ws_bus SHALL be combinational from the bus register and data_sram_rdata (zero added latency; result visible the cycle the instruction sits in this stage).
REQ-027 Latency: instruction accepted at edge N SHALL present ms_to_ws_valid during cycle N..N+1 and transfer at the first edge with ws_allowin=1.
REQ-028 When ws_allowin=0 with ms_valid=1, bus register and ms_valid SHALL hold, ms_allowin=0; rdata dependency is the execute stage's responsibility to re-issue.
REQ-029 Simultaneous transfer out and accept in SHALL replace the held instruction in the same edge with no bubble.

Reset
REQ-030 On reset assertion, ms_valid SHALL clear immediately (asynchronously), forcing ms_to_ws_valid=0, fwd_valid=0, ms_allowin=1.
REQ-031 On reset the bus register SHALL clear to all zeros; reset mid-operation SHALL discard the held instruction without writeback.
REQ-032 First capture after reset deassertion SHALL occur at the first rising edge with es_to_ms_valid=1.

Verification
REQ-033 lb, load_choice=2, rdata=0x12F45678 -> final_result=0xFFFFFFF4; lbu same -> 0x000000F4.
REQ-034 lh, load_choice=2, rdata=0x8001_1234 -> 0xFFFF8001; lhu -> 0x00008001.
REQ-035 lwl choice=1, rt=0xAABBCCDD, rdata=0x11223344 -> 0x3344CCDD; lwr choice=1 -> 0xAA112233.
REQ-036 ws_allowin=0 for 3 cycles with valid instruction -> ms_allowin=0, outputs stable; ws_allowin=1 -> transfer, next instruction accepted same edge.
REQ-037 gr_we=1, dest=0 -> fwd_valid=0; dest=5 -> fwd_valid=1, forwarded result equals final_result.
REQ-038 Assert reset between edges while ms_valid=1 -> ms_to_ws_valid drops before next edge; bus reads 0.
